ram_access_ctrl: RTL and testbench

- Request-side controller that sits directly upstream of the 256x4 `ram` block and is the sole driver of its `clk_i`-domain control pins and its bidirectional `data_io` bus.
- Converts a valid/ready request stream (read, write, fill-clear) into correctly sequenced `wr_en`/`rd_en`/`addr` strobes, with a guaranteed bus-turnaround gap.
- Returns read data on a one-cycle response pulse.
- Game logic (board/snake-body storage) talks to this block instead of toggling RAM pins directly.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_access_ctrl_tristate_buf.sv | 16 +
 rtl/ram_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared RAM geometry, request op encodings and controller state type.
//   RAM_AW / RAM_DW : default address / data width of the 256x4 RAM
//   OP_*            : req_op_i encodings (read, write, clear-fill, reserved)
//   ctrl_state_t    : ram_access_ctrl FSM states
package ram_pkg;
    localparam int RAM_AW = 8;
    localparam int RAM_DW = 4;
    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_RESP, S_TURN, S_CLEAR
    } ctrl_state_t;
endpackage

// File: rtl/ram_access_ctrl_tristate_buf.sv
// tristate_buf: DW-wide bidirectional pad buffer.
//   oe   : drive pad with din when high, release (high-Z) when low
//   din  : value driven onto the pad
//   dout : pad value as seen on the bus (own drive or external driver)
//   pad  : shared bidirectional bus
module tristate_buf #(
    parameter int DW = 4
) (
    input  logic          oe,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    inout  wire  [DW-1:0] pad
);
    assign pad  = oe ? din : {DW{1'bz}};
    assign dout = pad;
endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequences read/write/clear requests onto the RAM control pins and data bus.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   : request handshake; req_op_i/req_addr_i/req_wdata_i request payload
//   rsp_valid_o/rsp_rdata_o   : one-cycle response (read data or clear-complete with fill value)
//   busy_o                    : controller not idle
//   wr_en_o/rd_en_o/addr_o    : RAM control pins; data_io shared RAM data bus
module ram_access_ctrl
    import ram_pkg::*;
#(
    parameter int AW     = RAM_AW,
    parameter int DW     = RAM_DW,
    parameter int RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [1:0]    req_op_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          busy_o,
    output logic          wr_en_o,
    output logic          rd_en_o,
    output logic [AW-1:0] addr_o,
    inout  wire  [DW-1:0] data_io
);
    // One extra counter bit lets the clear sweep see "all 2**AW written" without wrapping.
    localparam int CW = AW + 1;

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d, bus_in;
    logic          wr_q, wr_d, rd_q, rd_d, rsp_q, rsp_d, ready_q, busy_q;

    assign cnt_inc = cnt_q + CW'(1);

    // Outputs are computed for the state being entered, so every pin is a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        rsp_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // ready_q gates acceptance so nothing is taken in the first cycle out of reset.
                if (req_valid_i && ready_q) begin
                    wdata_d = req_wdata_i;
                    cnt_d   = '0;
                    case (req_op_i)
                        OP_RD: begin
                            state_d = S_READ;
                            rd_d    = 1'b1;
                            addr_d  = req_addr_i;
                        end
                        OP_WR: begin
                            state_d = S_WRITE;
                            wr_d    = 1'b1;
                            addr_d  = req_addr_i;
                        end
                        OP_CLR: begin
                            state_d = S_CLEAR;
                            wr_d    = 1'b1;
                            addr_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    state_d = S_RESP;
                    rsp_d   = 1'b1;
                    rdata_d = bus_in;
                end else begin
                    cnt_d = cnt_inc;
                    rd_d  = 1'b1;
                end
            end
            S_RESP: state_d = S_TURN;
            S_TURN: state_d = S_IDLE;
            S_CLEAR: begin
                // cnt_q is the address being written; cnt_q[AW] marks the completion cycle.
                state_d = cnt_q[AW] ? S_IDLE : S_CLEAR;
                cnt_d   = cnt_q[AW] ? cnt_q : cnt_inc;
                addr_d  = cnt_q[AW] ? addr_q : cnt_inc[AW-1:0];
                wr_d    = !cnt_q[AW] && !cnt_inc[AW];
                rsp_d   = !cnt_q[AW] && cnt_inc[AW];
                rdata_d = (!cnt_q[AW] && cnt_inc[AW]) ? wdata_q : rdata_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rsp_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rsp_q   <= rsp_d;
            ready_q <= state_d == S_IDLE;
            busy_q  <= state_d != S_IDLE;
        end
    end

    tristate_buf #(.DW(DW)) u_buf (
        .oe   (wr_q),
        .din  (wdata_q),
        .dout (bus_in),
        .pad  (data_io)
    );

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_q;
    assign rsp_rdata_o = rdata_q;
    assign busy_o      = busy_q;
    assign wr_en_o     = wr_q;
    assign rd_en_o     = rd_q;
    assign addr_o      = addr_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: self-checking bench for ram_access_ctrl at RD_LAT=1 and RD_LAT=3.
module tb_ram_access_ctrl;
    import ram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       valid = 1'b0;
    logic       sel = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] addr = 8'h00;
    logic [3:0] wdata = 4'h0;

    logic       a_ready, a_rsp, a_busy, a_wr, a_rd, b_ready, b_rsp, b_busy, b_wr, b_rd;
    logic [3:0] a_rdata, b_rdata;
    logic [7:0] a_addr, b_addr;
    wire  [3:0] bus_a, bus_b;

    // Simple RAM behaviour on each bus: combinational read drive, write on clock edge.
    logic [3:0] mem_a [256];
    logic [3:0] mem_b [256];
    assign bus_a = a_rd ? mem_a[a_addr] : 4'bz;
    assign bus_b = b_rd ? mem_b[b_addr] : 4'bz;
    always @(posedge clk) begin
        if (a_wr) mem_a[a_addr] <= bus_a;
        if (b_wr) mem_b[b_addr] <= bus_b;
    end

    ram_access_ctrl #(.AW(8), .DW(4), .RD_LAT(1)) u_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid && !sel), .req_ready_o(a_ready),
        .req_op_i(op), .req_addr_i(addr), .req_wdata_i(wdata), .rsp_valid_o(a_rsp),
        .rsp_rdata_o(a_rdata), .busy_o(a_busy), .wr_en_o(a_wr), .rd_en_o(a_rd),
        .addr_o(a_addr), .data_io(bus_a)
    );
    ram_access_ctrl #(.AW(8), .DW(4), .RD_LAT(3)) u_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid && sel), .req_ready_o(b_ready),
        .req_op_i(op), .req_addr_i(addr), .req_wdata_i(wdata), .rsp_valid_o(b_rsp),
        .rsp_rdata_o(b_rdata), .busy_o(b_busy), .wr_en_o(b_wr), .rd_en_o(b_rd),
        .addr_o(b_addr), .data_io(bus_b)
    );

    logic       m_ready, m_rsp, m_busy, m_wr, m_rd;
    logic [3:0] m_rdata, m_bus;
    logic [7:0] m_addr;
    assign m_ready = sel ? b_ready : a_ready;
    assign m_rsp   = sel ? b_rsp   : a_rsp;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_wr    = sel ? b_wr    : a_wr;
    assign m_rd    = sel ? b_rd    : a_rd;
    assign m_rdata = sel ? b_rdata : a_rdata;
    assign m_bus   = sel ? bus_b   : bus_a;
    assign m_addr  = sel ? b_addr  : a_addr;

    int    n_chk = 0;
    int    n_fail = 0;
    string cur_tag = "";

    // Reference memory contents per DUT, maintained from the requests the bench issues.
    logic [3:0] exp_mem [2][256];

    int         r_rsp_n, r_lat, r_busy_n, r_wr_n, r_rd_n, r_bad;
    logic [3:0] r_data;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%s]: got %0h expected %0h", name, cur_tag, got, exp);
        end
    endtask

    // Issue one request (caller sits at a negedge), observe until ready returns, and
    // compare the transaction shape against what the request rules predict.
    task automatic run_op(input logic [1:0] o, input logic [7:0] ad, input logic [3:0] d);
        int rl, e_rsp, e_lat, e_busy, e_wr, e_rd, n, k;
        logic [3:0] e_data;
        rl = sel ? 3 : 1;
        e_rsp = 0; e_lat = 0; e_busy = 0; e_wr = 0; e_rd = 0; e_data = 4'h0;
        if (o == OP_RD) begin
            e_rsp = 1; e_data = exp_mem[sel][ad]; e_lat = rl + 1; e_busy = rl + 2; e_rd = rl;
        end else if (o == OP_WR) begin
            e_busy = 1; e_wr = 1;
        end else if (o == OP_CLR) begin
            e_rsp = 1; e_data = d; e_lat = 257; e_busy = 257; e_wr = 256;
        end
        cur_tag = $sformatf("lat%0d op%0d addr %02h data %0h", rl, o, ad, d);
        op = o; addr = ad; wdata = d; valid = 1'b1;
        n = 0;
        while (!m_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", int'(m_ready), 1);
        @(negedge clk);
        valid = 1'b0;
        r_rsp_n = 0; r_lat = 0; r_busy_n = 0; r_wr_n = 0; r_rd_n = 0; r_bad = 0; r_data = 4'h0;
        for (k = 1; k <= 600; k++) begin
            if (m_rsp) begin
                r_rsp_n++;
                r_lat = k;
                r_data = m_rdata;
            end
            if (m_busy) r_busy_n++;
            if (m_wr && m_rd) r_bad++;
            if (m_wr) begin
                if (m_bus !== d || m_addr !== (o == OP_CLR ? 8'(r_wr_n) : ad)) r_bad++;
                r_wr_n++;
            end
            if (m_rd) begin
                if (m_addr !== ad) r_bad++;
                r_rd_n++;
            end
            if (m_ready) break;
            @(negedge clk);
        end
        check("complete", int'(m_ready), 1);
        check("rsp_count", r_rsp_n, e_rsp);
        if (e_rsp == 1) begin
            check("rsp_data", int'(r_data), int'(e_data));
            check("rsp_latency", r_lat, e_lat);
        end
        check("busy_cycles", r_busy_n, e_busy);
        check("wr_pulses", r_wr_n, e_wr);
        check("rd_cycles", r_rd_n, e_rd);
        check("strobe_errors", r_bad, 0);
        if (o == OP_WR) exp_mem[sel][ad] = d;
        if (o == OP_CLR) for (int i = 0; i < 256; i++) exp_mem[sel][i] = d;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [3:0] wdata;
        logic       exp_rsp;
        logic [3:0] exp_data;
    } vec_t;

    initial begin
        vec_t       tbl [11];
        logic [7:0] bnd [6];
        int         k, n, r;
        logic [1:0] o;
        logic [7:0] ad;
        tbl[0]  = '{OP_CLR, 8'h00, 4'h5, 1'b1, 4'h5};
        tbl[1]  = '{OP_RD,  8'h00, 4'h0, 1'b1, 4'h5};
        tbl[2]  = '{OP_RD,  8'h7F, 4'h0, 1'b1, 4'h5};
        tbl[3]  = '{OP_RD,  8'hFF, 4'h0, 1'b1, 4'h5};
        tbl[4]  = '{OP_WR,  8'h3A, 4'h9, 1'b0, 4'h0};
        tbl[5]  = '{OP_RD,  8'h3A, 4'h0, 1'b1, 4'h9};
        tbl[6]  = '{OP_RSV, 8'h3A, 4'h2, 1'b0, 4'h0};
        tbl[7]  = '{OP_RD,  8'h3A, 4'h0, 1'b1, 4'h9};
        tbl[8]  = '{OP_WR,  8'h3A, 4'hA, 1'b0, 4'h0};
        tbl[9]  = '{OP_RD,  8'h3A, 4'h0, 1'b1, 4'hA};
        tbl[10] = '{OP_RD,  8'h3B, 4'h0, 1'b1, 4'h5};
        bnd = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};

        @(negedge clk);
        cur_tag = "reset";
        check("ready_in_reset", a_ready, 0);
        check("busy_in_reset", a_busy, 0);
        check("wr_in_reset", a_wr, 0);
        check("rd_in_reset", a_rd, 0);
        check("rsp_in_reset", a_rsp, 0);
        check("addr_in_reset", a_addr, 0);
        check("rdata_in_reset", a_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", a_ready, 1);

        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].op, tbl[i].addr, tbl[i].wdata);
            check("tbl_rsp", r_rsp_n, int'(tbl[i].exp_rsp));
            if (tbl[i].exp_rsp) check("tbl_data", int'(r_data), int'(tbl[i].exp_data));
        end

        // Read followed by a write request held high through the read.
        cur_tag = "held_request";
        op = OP_RD; addr = 8'h10; valid = 1'b1;
        check("held_idle_ready", a_ready, 1);
        @(negedge clk);
        op = OP_WR; addr = 8'h11; wdata = 4'h7;
        for (k = 1; k <= 20; k++) begin
            if (k == 2) begin
                check("held_rsp", a_rsp, 1);
                check("held_rdata", a_rdata, int'(exp_mem[0][8'h10]));
            end
            if (k == 3) begin
                check("turn_wr", a_wr, 0);
                check("turn_rd", a_rd, 0);
                check("turn_busy", a_busy, 1);
                check("turn_ready", a_ready, 0);
            end
            if (a_ready) break;
            @(negedge clk);
        end
        check("held_ready_cycle", k, 4);
        @(negedge clk);
        valid = 1'b0;
        check("held_wr", a_wr, 1);
        check("held_addr", a_addr, 'h11);
        check("held_bus", int'(bus_a), 'h7);
        exp_mem[0][8'h11] = 4'h7;
        @(negedge clk);
        run_op(OP_RD, 8'h11, 4'h0);

        // Reset while the clear sweep is writing address 0x40.
        cur_tag = "reset_mid_clear";
        op = OP_CLR; wdata = 4'hA; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        n = 0;
        while (!(a_wr && a_addr == 8'h40) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reached_0x40", a_addr, 'h40);
        #1 rst = 1'b1;
        #1;
        check("rst_ready", a_ready, 0);
        check("rst_busy", a_busy, 0);
        check("rst_wr", a_wr, 0);
        check("rst_rd", a_rd, 0);
        check("rst_rsp", a_rsp, 0);
        check("rst_addr", a_addr, 0);
        check("rst_rdata", a_rdata, 0);
        for (int i = 0; i < 64; i++) exp_mem[0][i] = 4'hA;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_mid_reset", a_ready, 1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (a_rsp) n++;
            @(negedge clk);
        end
        check("no_rsp_after_reset", n, 0);
        run_op(OP_RD, 8'h3F, 4'h0);
        run_op(OP_RD, 8'h40, 4'h0);

        // Randomized traffic on both read-latency builds.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            run_op(OP_CLR, 8'h00, 4'($urandom_range(0, 15)));
            if (s == 1) begin
                run_op(OP_WR, 8'h22, 4'hC);
                run_op(OP_RD, 8'h22, 4'h0);
                check("rdlat3_data", int'(r_data), 'hC);
                check("rdlat3_rd_cycles", r_rd_n, 3);
            end
            for (int i = 0; i < 40; i++) begin
                r = int'($urandom_range(0, 99));
                o = r < 45 ? OP_RD : r < 85 ? OP_WR : r < 97 ? OP_RSV : OP_CLR;
                ad = $urandom_range(0, 1) == 1 ? bnd[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
                run_op(o, ad, 4'($urandom_range(0, 15)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
